// File: rtl/mult_err_pkg.sv
// Shared types and default constants for the approximate-multiplier error monitor.
package mult_err_pkg;

  // Run-control states of the monitor.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Default sizing for an 8x8 multiplier characterisation run.
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_N_SAMPLES = 10000;
  localparam int DEF_CNT_W     = 14;
  localparam int DEF_SUM_W     = 32;

  // Largest 8x8 product (255*255); software divides MED by this to get MNED.
  localparam int PROD_8X8_MAX  = 65025;

endpackage

// File: rtl/mult_error_monitor_seq_udiv.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, W cycles per divide.
// done pulses for one cycle in the same cycle the final quotient appears.
module seq_udiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic          active;
  logic [CW-1:0] bits_left;
  logic [W:0]    rem_shift;
  logic [W:0]    rem_sub;

  // The partial remainder is always below the divisor, so the shifted value's trial
  // subtraction borrows (top bit set) exactly when the divisor does not fit.
  assign rem_shift = {rem, quo[W-1]};
  assign rem_sub   = rem_shift - {1'b0, divisor};
  assign quotient  = quo;

  // Load operands on start, then shift in one quotient bit per cycle until all W are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      quo       <= '0;
      active    <= 1'b0;
      bits_left <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem       <= '0;
        quo       <= dividend;
        active    <= 1'b1;
        bits_left <= CW'(W);
      end else if (active) begin
        if (!rem_sub[W]) begin
          rem <= rem_sub[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= rem_shift[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        bits_left <= bits_left - CW'(1);
        if (bits_left == CW'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_error_monitor.sv
// Receiver/checker for approximate-multiplier characterisation: accumulates error
// statistics over N_SAMPLES (exact, approximate) pairs, then divides out the MED.
module mult_error_monitor
  import mult_err_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] exact,
  input  logic [WIDTH-1:0] apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [SUM_W-1:0] sum_abs_ed,
  output logic [WIDTH-1:0] max_ed,
  output logic [SUM_W-1:0] med
);

  state_t state, next_state;

  logic             accept, last_accept, stats_clear;
  logic             ready_nxt, busy_nxt, done_nxt, div_start_nxt;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_quotient;
  logic [CNT_W-1:0] sample_cnt;

  logic signed [WIDTH:0] diff_c;
  logic [WIDTH-1:0]      abs_c;
  logic                  s1_valid, s1_mismatch;
  logic signed [WIDTH:0] s1_diff;
  logic [WIDTH-1:0]      s1_abs;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_cnt == CNT_W'(N_SAMPLES - 1));
  assign stats_clear = start && ((state == IDLE) || (state == DONE));

  assign diff_c = {1'b0, exact} - {1'b0, apprx};
  assign abs_c  = (exact >= apprx) ? (exact - apprx) : (apprx - exact);

  // State register plus the registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_start <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      div_start <= div_start_nxt;
    end
  end

  // Run sequencing: start only counts from IDLE/DONE; the last accept ends the run.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start)       next_state = RUN;
      RUN:        if (last_accept) next_state = DRAIN;
      DRAIN:                       next_state = DIV;
      DIV:        if (div_done)    next_state = DONE;
      default:                     next_state = IDLE;
    endcase
  end

  // Output decode; the divider is kicked in the first DIV cycle, once the last
  // pair has reached the accumulators.
  always_comb begin
    ready_nxt     = (next_state == RUN);
    busy_nxt      = (next_state == RUN) || (next_state == DRAIN) || (next_state == DIV);
    done_nxt      = (next_state == DONE);
    div_start_nxt = (state == DRAIN);
  end

  // Count accepted pairs so the run ends after exactly N_SAMPLES transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (stats_clear) begin
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // Stage 1: register the signed difference, its magnitude and the mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_diff     <= '0;
      s1_abs      <= '0;
      s1_mismatch <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff     <= diff_c;
        s1_abs      <= abs_c;
        s1_mismatch <= (exact != apprx);
      end
    end
  end

  // Stage 2: fold each registered difference into the running statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      sum_ed     <= '0;
      sum_abs_ed <= '0;
      max_ed     <= '0;
    end else if (stats_clear) begin
      err_count  <= '0;
      sum_ed     <= '0;
      sum_abs_ed <= '0;
      max_ed     <= '0;
    end else if (s1_valid) begin
      err_count  <= err_count + CNT_W'(s1_mismatch);
      sum_ed     <= sum_ed + {{(SUM_W - WIDTH - 1){s1_diff[WIDTH]}}, s1_diff};
      sum_abs_ed <= sum_abs_ed + {{(SUM_W - WIDTH){1'b0}}, s1_abs};
      if (s1_abs > max_ed) begin
        max_ed <= s1_abs;
      end
    end
  end

  // Capture the quotient as the monitor enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      med <= '0;
    end else if (stats_clear) begin
      med <= '0;
    end else if ((state == DIV) && div_done) begin
      med <= div_quotient;
    end
  end

  seq_udiv #(
    .W(SUM_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_abs_ed),
    .divisor  (SUM_W'(N_SAMPLES)),
    .quotient (div_quotient),
    .done     (div_done)
  );

endmodule

// File: tb/tb_mult_error_monitor.sv
// Scoreboard bench for mult_error_monitor: each run's expected statistics are
// computed from the pair list with plain integer arithmetic and queued; a monitor
// pops and compares when done rises.
module tb_mult_error_monitor;
  import mult_err_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 14;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  exact = '0;
  logic [W-1:0]  apprx = '0;
  logic          busy, done;
  logic [CW-1:0] err_count;
  logic [SW-1:0] sum_ed, sum_abs_ed, med;
  logic [W-1:0]  max_ed;

  mult_error_monitor #(
    .WIDTH(W), .N_SAMPLES(N), .CNT_W(CW), .SUM_W(SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exact      (exact),
    .apprx      (apprx),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .sum_ed     (sum_ed),
    .sum_abs_ed (sum_abs_ed),
    .max_ed     (max_ed),
    .med        (med)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint err;
    longint sum;
    longint abs_sum;
    longint max_e;
    longint med;
  } result_t;

  result_t exp_q[$];
  int      compared = 0;
  int      mismatched = 0;
  int      ex_arr[N];
  int      ap_arr[N];
  logic    done_q = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic boundFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: bound expired, got no response, expected one", name);
  endtask

  // Reference statistics straight from the definitions over the pair list.
  function automatic result_t modelRun();
    result_t r;
    r = '{0, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      longint d, a;
      d = longint'(ex_arr[i]) - longint'(ap_arr[i]);
      a = (d < 0) ? -d : d;
      if (d != 0) r.err++;
      r.sum     += d;
      r.abs_sum += a;
      if (a > r.max_e) r.max_e = a;
    end
    r.med = r.abs_sum / N;
    return r;
  endfunction

  // Monitor: on each rising edge of done, compare against the oldest expected run.
  always @(negedge clk) begin
    result_t e;
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        boundFail("unexpected_done");
      end else begin
        e = exp_q.pop_front();
        checkOutput("err_count", longint'(err_count), e.err);
        checkOutput("sum_ed", longint'($signed(sum_ed)), e.sum);
        checkOutput("sum_abs_ed", longint'(sum_abs_ed), e.abs_sum);
        checkOutput("max_ed", longint'(max_ed), e.max_e);
        checkOutput("med", longint'(med), e.med);
        checkOutput("busy_in_done", longint'(busy), 0);
      end
    end
    done_q = done;
  end

  // One run: queue the expectation, pulse start, check the clear, then hand the
  // pairs over with optional gaps, an ignored mid-run start and a held fifth pair.
  task automatic applyStimulus(input int gap_pct, input bit start_mid_run, input bit hold_extra);
    bit accepted;
    exp_q.push_back(modelRun());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("clear_done", longint'(done), 0);
    checkOutput("clear_err_count", longint'(err_count), 0);
    checkOutput("clear_sum_abs_ed", longint'(sum_abs_ed), 0);
    checkOutput("clear_med", longint'(med), 0);
    checkOutput("run_busy", longint'(busy), 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
        in_valid = 1'b0;
        exact = W'($urandom);
        @(posedge clk); #1;
      end
      if (start_mid_run && i == 2) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      in_valid = 1'b1;
      exact = W'(ex_arr[i]);
      apprx = W'(ap_arr[i]);
      accepted = 1'b0;
      for (int c = 0; c < 50 && !accepted; c++) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk); #1;
      end
      if (!accepted) boundFail("accept_timeout");
      in_valid = 1'b0;
    end
    if (hold_extra) begin
      in_valid = 1'b1;
      exact = 16'd500;
      apprx = 16'd0;
      @(negedge clk);
      checkOutput("ready_after_last", longint'(in_ready), 0);
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // A start pulse landing while the divider is running must be ignored.
  task automatic startDuringDiv();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checkOutput("busy_in_div", longint'(busy), 1);
  endtask

  task automatic waitDone();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) boundFail("done_timeout");
    @(negedge clk);
  endtask

  task automatic setPairs(input int e0, a0, e1, a1, e2, a2, e3, a3);
    ex_arr[0] = e0; ap_arr[0] = a0;
    ex_arr[1] = e1; ap_arr[1] = a1;
    ex_arr[2] = e2; ap_arr[2] = a2;
    ex_arr[3] = e3; ap_arr[3] = a3;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ap;
    $display("[TB] starting mult_error_monitor bench");
    #1 rst_n = 1'b0;
    #20;
    checkOutput("reset_in_ready", longint'(in_ready), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_sum_abs_ed", longint'(sum_abs_ed), 0);
    checkOutput("reset_med", longint'(med), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_in_ready", longint'(in_ready), 0);

    $display("[TB] exact-match run");
    setPairs(100, 100, 0, 0, PROD_8X8_MAX, PROD_8X8_MAX, 7, 7);
    applyStimulus(0, 1'b0, 1'b0);
    waitDone();

    $display("[TB] mixed-error run");
    setPairs(100, 96, 50, 58, 1000, 1000, 0, 3);
    applyStimulus(0, 1'b0, 1'b0);
    waitDone();

    $display("[TB] mixed-error run with gaps and a held fifth pair");
    applyStimulus(50, 1'b0, 1'b1);
    waitDone();

    $display("[TB] restart with four (10,0) pairs");
    setPairs(10, 0, 10, 0, 10, 0, 10, 0);
    applyStimulus(0, 1'b0, 1'b0);
    waitDone();

    $display("[TB] ignored start during RUN and DIV");
    setPairs(100, 96, 50, 58, 1000, 1000, 0, 3);
    applyStimulus(20, 1'b1, 1'b0);
    startDuringDiv();
    waitDone();

    $display("[TB] reset mid-run");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; exact = 16'd10; apprx = 16'd0;
    @(posedge clk); #1 exact = 16'd0; apprx = 16'd5;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("live_sum_abs_ed", longint'(sum_abs_ed), 15);
    checkOutput("live_sum_ed", longint'($signed(sum_ed)), 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_err_count", longint'(err_count), 0);
    checkOutput("midreset_sum_abs_ed", longint'(sum_abs_ed), 0);
    checkOutput("midreset_in_ready", longint'(in_ready), 0);
    checkOutput("midreset_busy", longint'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_in_ready", longint'(in_ready), 0);
    checkOutput("post_reset_busy", longint'(busy), 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        ex_arr[i] = int'($urandom_range(0, 65535));
        case ($urandom_range(0, 3))
          0: ap = ex_arr[i];
          1: ap = ex_arr[i] + int'($urandom_range(0, 20)) - 10;
          2: ap = int'($urandom_range(0, 65535));
          default: ap = (ex_arr[i] < 32768) ? 65535 : 0;
        endcase
        if (ap < 0) ap = 0;
        if (ap > 65535) ap = 65535;
        ap_arr[i] = ap;
      end
      applyStimulus(int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) startDuringDiv();
      waitDone();
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) boundFail("pending_results");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_error_monitor.md
Name: mult_error_monitor

Overview:
- On-chip receiver and checker for approximate-multiplier characterisation.
- Accepts a stream of (exact, approximate) product pairs from the multiplier harness over a valid/ready handshake.
- Accumulates error statistics over a fixed sample count: error count, signed and absolute error-distance sums, and maximum absolute error.
- At the end of the run, computes MED (mean absolute error distance) with a sequential divider and presents all results with a done flag.

Parameters:
- WIDTH, 16, product width (8x8 multiplier).
- N_SAMPLES, 10000, pairs accepted per run.
- CNT_W, 14, sample/error counter width; must satisfy 2^CNT_W > N_SAMPLES.
- SUM_W, 32, accumulator width; must satisfy 2^(SUM_W-1) > N_SAMPLES*(2^WIDTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear statistics and begin a run.
- in_valid  in  1  pair valid.
- in_ready  out  1  monitor accepts a pair this cycle.
- exact  in  WIDTH  reference product A*B.
- apprx  in  WIDTH  approximate multiplier output.
- busy  out  1  high in RUN, DRAIN, DIV.
- done  out  1  results valid; held until next start.
- err_count  out  CNT_W  pairs with exact != apprx.
- sum_ed  out  SUM_W  signed sum of (exact - apprx).
- sum_abs_ed  out  SUM_W  sum of |exact - apprx|.
- max_ed  out  WIDTH  largest |exact - apprx|.
- med  out  SUM_W  floor(sum_abs_ed / N_SAMPLES).

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output register and counter is 0, including in_ready, busy, done and all statistics.
- FSM states: IDLE, RUN, DRAIN, DIV, DONE.
  - IDLE/DONE -> RUN on start. Entering RUN clears sample_cnt, err_count, sum_ed, sum_abs_ed, max_ed, med and done.
  - start during RUN, DRAIN or DIV is ignored.
  - RUN -> DRAIN in the cycle the N_SAMPLES-th pair is accepted.
  - DRAIN -> DIV after 1 cycle; the pipeline is empty once DRAIN completes.
  - DIV -> DONE when the divider asserts its done signal.
- Handshake:
  - in_ready = (state==RUN), registered.
  - A transfer occurs when in_valid && in_ready.
  - in_ready drops in the cycle after the last accept, so no pair beyond N_SAMPLES is taken.
  - in_valid may toggle freely; gaps do not affect results.
- Pipeline:
  - Stage 1 registers diff = exact - apprx as a signed (WIDTH+1)-bit value, abs_diff (WIDTH bits), mismatch flag and a stage valid bit.
  - Stage 2 updates the accumulators when the stage-1 valid bit is set.
  - Latency from accept to statistics update: 2 cycles.
- Arithmetic:
  - sum_ed is signed two's complement; diff is sign-extended to SUM_W.
  - sum_abs_ed is unsigned; abs_diff is zero-extended.
  - max_ed is updated on strictly greater.
  - err_count increments only when the mismatch flag is set.
  - Accumulators do not saturate; the parameter constraints guarantee no overflow.
- Divider:
  - Restoring, unsigned, one quotient bit per cycle, SUM_W cycles.
  - Dividend is sum_abs_ed, divisor is N_SAMPLES.
  - med is loaded from the quotient on completion, and done rises in the same cycle as the DONE entry.
- Statistic outputs are stable in DONE; they also update live during RUN for debug.
- Reset mid-run: everything returns to IDLE/zero immediately; no partial results are retained.

Decomposition:
- Shared package mem_pkg... no: shared package mult_err_pkg holds:
  - state enum: IDLE, RUN, DRAIN, DIV, DONE;
  - default WIDTH, N_SAMPLES, CNT_W and SUM_W constants;
  - 8x8 product constant 65025, used as the MNED normaliser by software.
- One sub-module: seq_udiv (SUM_W-bit sequential restoring divider).
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, done.
  - Same clock and reset.

Test Plan:
- Exact match: start with N_SAMPLES=4; send (100,100), (0,0), (65025,65025), (7,7) -> err_count=0, sum_ed=0, sum_abs_ed=0, max_ed=0, med=0; done high after DRAIN+DIV.
- Mixed errors: N_SAMPLES=4; send (100,96), (50,58), (1000,1000), (0,3) -> err_count=3, sum_ed=-7, sum_abs_ed=15, max_ed=8, med=3.
- Backpressure and gaps: same stream as the mixed-errors case with in_valid low for random gaps -> identical results. A fifth valid pair held after the 4th accept sees in_ready=0 and is not counted.
- Restart: after DONE, pulse start -> done=0 and statistics cleared next cycle. A new run of four (10,0) pairs -> sum_abs_ed=40, max_ed=10, med=10.
- Reset mid-run: assert rst_n=0 after 2 accepts -> all outputs 0 asynchronously; after release, state IDLE and in_ready=0 until start.
- Ignored start: pulse start during RUN and during DIV -> no clear, final results unchanged from the undisturbed run.
